poly_eval_horner: RTL and testbench

Parametrised polynomial evaluator that computes y = c[DEGREE]·x^DEGREE + … + c[1]·x + c[0] using Horner's rule, one multiply-accumulate per clock. Operands are entered one at a time on a shared data bus using the lab's press/release `go` handshake. It generalises the fixed Ax² + Bx + C datapath/control pair to any degree and width. It adds three things that pair lacks: an overflow flag, a completion strobe, and a coefficient-reuse mode in which only x is re-entered.

---
 rtl/poly_eval_horner.sv | 127 ++++++++++++
 tb/tb_poly_eval_horner.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/poly_eval_horner.sv
// Polynomial evaluator using Horner's rule. It performs one multiply-accumulate per clock.
// Coefficients (highest first) and x are entered one at a time through a press/release go handshake.
module poly_eval_horner #(
    parameter int WIDTH  = 8,
    parameter int DEGREE = 3,
    parameter int IW     = $clog2(DEGREE + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go,
    input  logic             reuse_coef,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] result,
    output logic             overflow,
    output logic             done,
    output logic             busy,
    output logic [IW-1:0]    coef_idx,
    output logic             x_pending
);

    typedef enum logic [2:0] {
        LD_COEF   = 3'd0,
        LD_COEF_W = 3'd1,
        LD_X      = 3'd2,
        LD_X_W    = 3'd3,
        CALC      = 3'd4,
        DONE      = 3'd5
    } state_t;

    state_t             state_r;
    logic [IW-1:0]      k_r;
    logic [WIDTH-1:0]   c_r [0:DEGREE];
    logic [WIDTH-1:0]   x_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   result_r;
    logic               overflow_r;

    logic [2*WIDTH-1:0] prod_s;
    logic [2*WIDTH:0]   mac_s;
    logic               mac_ovf_s;

    // Full-precision Horner step: acc * x + c[k]; any bit above WIDTH marks an overflow.
    assign prod_s    = {{WIDTH{1'b0}}, acc_r} * {{WIDTH{1'b0}}, x_r};
    assign mac_s     = {1'b0, prod_s} + {{(WIDTH + 1){1'b0}}, c_r[k_r]};
    assign mac_ovf_s = |mac_s[2*WIDTH:WIDTH];

    assign result    = result_r;
    assign overflow  = overflow_r;
    assign done      = (state_r == DONE);
    assign busy      = (state_r == CALC);
    assign x_pending = (state_r == LD_X) || (state_r == LD_X_W);
    assign coef_idx  = k_r;

    // Control FSM together with the operand, accumulator and result registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r    <= LD_COEF;
            k_r        <= IW'(DEGREE);
            for (int i = 0; i <= DEGREE; i++) begin
                c_r[i] <= {WIDTH{1'b0}};
            end
            x_r        <= {WIDTH{1'b0}};
            acc_r      <= {WIDTH{1'b0}};
            result_r   <= {WIDTH{1'b0}};
            overflow_r <= 1'b0;
        end else begin
            case (state_r)
                LD_COEF: begin
                    if (go) begin
                        c_r[k_r] <= data_in;
                        state_r  <= LD_COEF_W;
                    end
                end
                LD_COEF_W: begin
                    if (!go) begin
                        if (k_r == IW'(0)) begin
                            state_r <= LD_X;
                        end else begin
                            k_r     <= k_r - IW'(1);
                            state_r <= LD_COEF;
                        end
                    end
                end
                LD_X: begin
                    if (go) begin
                        x_r     <= data_in;
                        state_r <= LD_X_W;
                    end
                end
                LD_X_W: begin
                    // Overflow restarts here so it only ever describes the evaluation in flight.
                    if (!go) begin
                        acc_r      <= c_r[DEGREE];
                        k_r        <= IW'(DEGREE - 1);
                        overflow_r <= 1'b0;
                        state_r    <= CALC;
                    end
                end
                CALC: begin
                    acc_r <= mac_s[WIDTH-1:0];
                    if (mac_ovf_s) begin
                        overflow_r <= 1'b1;
                    end
                    if (k_r == IW'(0)) begin
                        result_r <= mac_s[WIDTH-1:0];
                        state_r  <= DONE;
                    end else begin
                        k_r <= k_r - IW'(1);
                    end
                end
                DONE: begin
                    if (reuse_coef) begin
                        state_r <= LD_X;
                    end else begin
                        k_r     <= IW'(DEGREE);
                        state_r <= LD_COEF;
                    end
                end
                default: begin
                    k_r     <= IW'(DEGREE);
                    state_r <= LD_COEF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_poly_eval_horner.sv
// Directed bench for poly_eval_horner.
// It uses the default instance (8-bit, cubic) and a narrow linear instance (4-bit, degree 1).
module tb_poly_eval_horner;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0;
    logic       reuse_coef = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic [7:0] result;
    logic       overflow, done, busy, x_pending;
    logic [1:0] coef_idx;

    logic       go2 = 1'b0;
    logic       reuse2 = 1'b0;
    logic [3:0] data2 = 4'h0;
    logic [3:0] result2;
    logic       ovf2, done2, busy2, xp2;
    logic [0:0] cidx2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    poly_eval_horner dut (
        .clk(clk), .reset(reset), .go(go), .reuse_coef(reuse_coef), .data_in(data_in),
        .result(result), .overflow(overflow), .done(done), .busy(busy),
        .coef_idx(coef_idx), .x_pending(x_pending)
    );

    poly_eval_horner #(.WIDTH(4), .DEGREE(1)) dut2 (
        .clk(clk), .reset(reset), .go(go2), .reuse_coef(reuse2), .data_in(data2),
        .result(result2), .overflow(ovf2), .done(done2), .busy(busy2),
        .coef_idx(cidx2), .x_pending(xp2)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [7:0] v);
        data_in = v;
        go = 1'b1;
        tick();
        go = 1'b0;
        tick();
    endtask

    task automatic press2(input logic [3:0] v);
        data2 = v;
        go2 = 1'b1;
        tick();
        go2 = 1'b0;
        tick();
    endtask

    // Called right after the x release edge (E0); observes 8 cycles of the evaluation.
    task automatic run_calc(output int busy_cnt, output int done_cnt, output int done_at,
                            output logic [7:0] res, output logic ovf, output logic ovf_calc,
                            output logic xp_after);
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        res      = 8'h00;
        ovf      = 1'b0;
        ovf_calc = overflow;
        xp_after = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) begin
                    done_at = i;
                    res = result;
                    ovf = overflow;
                end
            end
            if (done_at >= 0 && i == done_at + 1) xp_after = x_pending;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL reset_result: got %h, expected 00", result); end
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow: got %b, expected 0", overflow); end
        n_checks++; if (done !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL reset_done_busy: got %b%b, expected 00", done, busy); end
        n_checks++; if (coef_idx !== 2'd3) begin n_fail++; $display("FAIL reset_coef_idx: got %0d, expected 3", coef_idx); end
        n_checks++; if (x_pending !== 1'b0) begin n_fail++; $display("FAIL reset_x_pending: got %b, expected 0", x_pending); end
        n_checks++; if (cidx2 !== 1'b1 || result2 !== 4'h0) begin n_fail++; $display("FAIL reset_small: got idx %b res %h, expected 1 0", cidx2, result2); end
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int bc, dc, da;
        logic [7:0] r;
        logic o, oc, xp;
        press(8'd1); press(8'd2); press(8'd3); press(8'd4);
        n_checks++; if (x_pending !== 1'b1) begin n_fail++; $display("FAIL basic_x_pending: got %b, expected 1", x_pending); end
        reuse_coef = 1'b1;
        press(8'd2);
        run_calc(bc, dc, da, r, o, oc, xp);
        n_checks++; if (r !== 8'h1A) begin n_fail++; $display("FAIL basic_result: got %h, expected 1a", r); end
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL basic_overflow: got %b, expected 0", o); end
        n_checks++; if (bc !== 3) begin n_fail++; $display("FAIL basic_busy_cycles: got %0d, expected 3", bc); end
        n_checks++; if (da !== 3 || dc !== 1) begin n_fail++; $display("FAIL basic_done_timing: got at %0d count %0d, expected at 3 count 1", da, dc); end
        n_checks++; if (xp !== 1'b1) begin n_fail++; $display("FAIL basic_reuse_x_pending: got %b, expected 1", xp); end
    endtask

    task automatic test_reuse();
        int bc, dc, da;
        logic [7:0] r;
        logic o, oc, xp;
        reuse_coef = 1'b0;
        press(8'd3);
        run_calc(bc, dc, da, r, o, oc, xp);
        n_checks++; if (r !== 8'h3A) begin n_fail++; $display("FAIL reuse_result: got %h, expected 3a", r); end
        n_checks++; if (dc !== 1 || bc !== 3) begin n_fail++; $display("FAIL reuse_pulses: got done %0d busy %0d, expected 1 3", dc, bc); end
        n_checks++; if (coef_idx !== 2'd3 || x_pending !== 1'b0) begin n_fail++; $display("FAIL reuse_back_to_coef: got idx %0d xp %b, expected 3 0", coef_idx, x_pending); end
    endtask

    task automatic test_overflow();
        int bc, dc, da;
        logic [7:0] r;
        logic o, oc, xp;
        press(8'd1); press(8'd0); press(8'd0); press(8'd0);
        reuse_coef = 1'b1;
        press(8'd7);
        run_calc(bc, dc, da, r, o, oc, xp);
        n_checks++; if (r !== 8'h57) begin n_fail++; $display("FAIL ovf_result: got %h, expected 57", r); end
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b, expected 1", o); end
        reuse_coef = 1'b0;
        press(8'd2);
        n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_clear_at_start: got %b, expected 0", overflow); end
        run_calc(bc, dc, da, r, o, oc, xp);
        n_checks++; if (r !== 8'h08) begin n_fail++; $display("FAIL ovf_rerun_result: got %h, expected 08", r); end
        n_checks++; if (o !== 1'b0) begin n_fail++; $display("FAIL ovf_rerun_flag: got %b, expected 0", o); end
    endtask

    task automatic test_held_key();
        int bc, dc, da;
        logic [7:0] r;
        logic o, oc, xp;
        data_in = 8'd5;
        go = 1'b1;
        tick();
        for (int i = 0; i < 19; i++) begin
            data_in = 8'(8'hA0 + i);
            tick();
            n_checks++; if (coef_idx !== 2'd3) begin n_fail++; $display("FAIL held_coef_idx: got %0d, expected 3 (cycle %0d)", coef_idx, i); end
        end
        go = 1'b0;
        tick();
        n_checks++; if (coef_idx !== 2'd2) begin n_fail++; $display("FAIL held_release_idx: got %0d, expected 2", coef_idx); end
        press(8'd0); press(8'd0); press(8'd0);
        press(8'd2);
        run_calc(bc, dc, da, r, o, oc, xp);
        n_checks++; if (r !== 8'h28) begin n_fail++; $display("FAIL held_result: got %h, expected 28", r); end
    endtask

    task automatic test_reset_mid_calc();
        int dc;
        press(8'd1); press(8'd2); press(8'd3); press(8'd4);
        press(8'd2);
        tick();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL midrst_busy_before: got %b, expected 1", busy); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy); end
        n_checks++; if (result !== 8'h00) begin n_fail++; $display("FAIL midrst_result: got %h, expected 00", result); end
        n_checks++; if (coef_idx !== 2'd3) begin n_fail++; $display("FAIL midrst_coef_idx: got %0d, expected 3", coef_idx); end
        dc = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) dc++;
            tick();
        end
        n_checks++; if (dc !== 0) begin n_fail++; $display("FAIL midrst_no_done: got %0d pulses, expected 0", dc); end
    endtask

    task automatic test_param();
        int bc, dc, da;
        logic [3:0] r;
        logic o;
        bc = 0; dc = 0; da = -1; r = 4'h0; o = 1'b0;
        n_checks++; if (cidx2 !== 1'b1) begin n_fail++; $display("FAIL small_idx_start: got %b, expected 1", cidx2); end
        press2(4'd3); press2(4'd5);
        press2(4'd4);
        for (int i = 0; i < 6; i++) begin
            if (busy2) bc++;
            if (done2) begin
                dc++;
                if (da < 0) begin da = i; r = result2; o = ovf2; end
            end
            tick();
        end
        n_checks++; if (r !== 4'h1) begin n_fail++; $display("FAIL small_result: got %h, expected 1", r); end
        n_checks++; if (o !== 1'b1) begin n_fail++; $display("FAIL small_overflow: got %b, expected 1", o); end
        n_checks++; if (bc !== 1 || da !== 1 || dc !== 1) begin n_fail++; $display("FAIL small_timing: got busy %0d done_at %0d done %0d, expected 1 1 1", bc, da, dc); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_reuse();
        test_overflow();
        test_held_key();
        test_reset_mid_calc();
        test_param();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
